add16_share_ctrl: RTL and testbench

//  Time-shares one clocked 16-bit adder datapath (operands in, sum out after fixed latency) between

---
 rtl/add16_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/add16_share_ctrl.sv | 118 +++++++++++
 tb/tb_add16_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add16_pkg.sv
// rtl/add16_pkg.sv - shared constants and FSM encoding for the shared 16-bit adder controller
package add16_pkg;

   localparam int ADD_WIDTH   = 16;
   localparam int DEF_ADD_LAT = 1;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts just after last_grant
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_idx,
   output logic                    gnt_any
);

   localparam int IW = $clog2(NREQ);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         if (!gnt_any && req[idx]) begin
            gnt_any  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/add16_share_ctrl.sv
// rtl/add16_share_ctrl.sv - time-shares one clocked adder between NREQ requesters
module add16_share_ctrl
   import add16_pkg::*;
#(
   parameter int WIDTH   = ADD_WIDTH,
   parameter int NREQ    = 4,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]          add_a,
   output logic [WIDTH-1:0]          add_b,
   input  logic [WIDTH-1:0]          add_sum,
   input  logic                      add_cout,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]          rsp_sum,
   output logic                      rsp_cout,
   output logic                      busy,
   output logic [15:0]               op_count
);

   localparam int IW = $clog2(NREQ);

   state_t             state_q;
   logic [IW-1:0]      last_q;
   logic [IW-1:0]      id_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               rv_q;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [15:0]        opc_q;

   logic [NREQ-1:0]    gnt;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req        (req_valid),
      .last_grant (last_q),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   // Accept pulse only while idle so an issue can never overlap a pending response.
   assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= IW'(NREQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         rv_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         opc_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_any) begin
                  a_q     <= req_a[gnt_idx*WIDTH +: WIDTH];
                  b_q     <= req_b[gnt_idx*WIDTH +: WIDTH];
                  id_q    <= gnt_idx;
                  cnt_q   <= CNT_W'(ADD_LAT);
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  sum_q   <= add_sum;
                  cout_q  <= add_cout;
                  rv_q    <= 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  last_q  <= id_q;
                  opc_q   <= opc_q + 16'd1;
                  rv_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               rv_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign add_a     = a_q;
   assign add_b     = b_q;
   assign rsp_valid = rv_q;
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign busy      = busy_q;
   assign op_count  = opc_q;

endmodule

// File: tb/tb_add16_share_ctrl.sv
// tb/tb_add16_share_ctrl.sv - self-checking bench for add16_share_ctrl against a transaction-level model
module tb_add16_share_ctrl;

   localparam int W       = 16;
   localparam int NREQ    = 4;
   localparam int ADD_LAT = 1;
   localparam int IW      = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [W-1:0]      add_a, add_b, add_sum;
   logic              add_cout;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_cout;
   logic              busy;
   logic [15:0]       op_count;

   add16_share_ctrl #(.WIDTH(W), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Adder stand-in: result settles within one cycle of stable operands.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   logic [15:0]     pa [NREQ][$];
   logic [15:0]     pb [NREQ][$];
   logic [NREQ-1:0] ready_seen = '0;
   bit              rdy_rand = 1'b0;

   task automatic post(input int i, input logic [15:0] a, input logic [15:0] b);
      pa[i].push_back(a);
      pb[i].push_back(b);
   endtask

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && ready_seen[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && pa[i].size() > 0) begin
            req_a[i*W +: W] = pa[i].pop_front();
            req_b[i*W +: W] = pb[i].pop_front();
            req_valid[i]    = 1'b1;
         end
      end
      if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
   end

   int          mq_id [$];
   logic [16:0] mq_sum [$];
   int          grant_log [$];
   int          m_last = NREQ - 1;
   logic [15:0] m_cnt  = '0;
   int          cyc    = 0;
   int          g_cyc  = 0;

   always @(negedge clk) begin : mon
      int              exp_idx;
      logic [NREQ-1:0] exp_rdy;
      bit              was_empty;
      bit              exp_rv;
      cyc++;
      if (rst) begin
         mq_id.delete();
         mq_sum.delete();
         m_last     = NREQ - 1;
         m_cnt      = '0;
         ready_seen = '0;
      end else begin
         ready_seen = req_ready;
         was_empty  = (mq_id.size() == 0);
         chk("op_count", 32'(op_count), 32'(m_cnt));
         chk("busy", 32'(busy), 32'(!was_empty));
         exp_idx = -1;
         exp_rdy = '0;
         if (was_empty) begin
            for (int k = 1; k <= NREQ; k++)
               if (exp_idx < 0 && req_valid[(m_last + k) % NREQ]) exp_idx = (m_last + k) % NREQ;
         end
         if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         exp_rv = !was_empty && (cyc - g_cyc >= ADD_LAT + 1);
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (rsp_valid && !was_empty) begin
            chk("rsp_id", 32'(rsp_id), 32'(mq_id[0]));
            chk("rsp_sum", 32'(rsp_sum), 32'(mq_sum[0][15:0]));
            chk("rsp_cout", 32'(rsp_cout), 32'(mq_sum[0][16]));
            if (rsp_ready) begin
               m_last = mq_id.pop_front();
               void'(mq_sum.pop_front());
               m_cnt = m_cnt + 16'd1;
            end
         end
         if (exp_idx >= 0 && req_ready != '0) begin
            mq_id.push_back(exp_idx);
            mq_sum.push_back({1'b0, req_a[exp_idx*W +: W]} + {1'b0, req_b[exp_idx*W +: W]});
            grant_log.push_back(exp_idx);
            g_cyc = cyc;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic wait_grant(input int i);
      bit ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = req_ready[i];
      end
      chk("grant_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_rsp();
      bit ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = rsp_valid;
      end
      chk("rsp_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int t = 0; t < 2000 && !idle; t++) begin
         @(negedge clk);
         idle = 1'b1;
         for (int i = 0; i < NREQ; i++) if (pa[i].size() != 0) idle = 1'b0;
         if (req_valid != '0 || busy || rsp_valid) idle = 1'b0;
      end
      chk("reach_idle", 32'(idle), 32'd1);
   endtask

   initial begin : test
      int lat;
      int exp_order [4];
      int n_posted [NREQ];
      int n_seen;
      bit done;
      exp_order = '{0, 2, 0, 2};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      post(0, 16'd2, 16'd4);
      wait_grant(0);
      lat = 0;
      for (int t = 0; t < 50 && !rsp_valid; t++) begin
         @(negedge clk);
         lat++;
      end
      chk("smoke_latency", 32'(lat), 32'(ADD_LAT + 1));
      chk("smoke_sum", 32'(rsp_sum), 32'd6);
      chk("smoke_id", 32'(rsp_id), 32'd0);
      chk("smoke_cout", 32'(rsp_cout), 32'd0);
      wait_idle();

      post(1, 16'd34952, 16'd34952);
      wait_rsp();
      chk("carry_sum", 32'(rsp_sum), 32'd4368);
      chk("carry_cout", 32'(rsp_cout), 32'd1);
      chk("carry_id", 32'(rsp_id), 32'd1);
      wait_idle();

      do_reset();
      grant_log.delete();
      post(0, 16'd10, 16'd1);
      post(2, 16'd20, 16'd2);
      post(0, 16'd30, 16'd3);
      post(2, 16'd40, 16'd4);
      wait_idle();
      chk("fair_count", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < grant_log.size()) chk("fair_order", 32'(grant_log[k]), 32'(exp_order[k]));

      rsp_ready = 1'b0;
      post(3, 16'd100, 16'd200);
      post(1, 16'd7, 16'd8);
      wait_rsp();
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_sum", 32'(rsp_sum), 32'd300);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_no_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      wait_idle();

      do_reset();
      post(0, 16'd5, 16'd6);
      wait_grant(0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rstw_op_count", 32'(op_count), 32'd0);
         chk("rstw_add_a", 32'(add_a), 32'd0);
         chk("rstw_rsp_sum", 32'(rsp_sum), 32'd0);
         chk("rstw_busy", 32'(busy), 32'd0);
      end

      do_reset();
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) n_posted[i] = 0;
      rdy_rand = 1'b1;
      for (int k = 0; k < 10; k++) begin
         int r;
         r = $urandom_range(0, NREQ - 1);
         post(r, 16'($urandom_range(0, 9999)), 16'($urandom_range(0, 19999)));
         n_posted[r]++;
      end
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         @(negedge clk);
         done = (op_count == 16'd10);
      end
      rdy_rand = 1'b0;
      rsp_ready = 1'b1;
      chk("rand_done", 32'(done), 32'd1);
      chk("rand_op_count", 32'(op_count), 32'd10);
      chk("rand_grants", 32'(grant_log.size()), 32'd10);
      for (int i = 0; i < NREQ; i++) begin
         n_seen = 0;
         foreach (grant_log[j]) if (grant_log[j] == i) n_seen++;
         chk("rand_per_req", 32'(n_seen), 32'(n_posted[i]));
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
